// File: rtl/led_fade_scheduler_if.sv
// Command port for led_fade_scheduler: one target-brightness write per transfer.
// A transfer completes on a rising clk_50 edge where cmd_valid && cmd_ready; once raised, the
// master holds cmd_valid and the payload stable until that edge, and ready never depends on valid.
interface led_fade_scheduler_if #(
    parameter int CH_W = 2
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [CH_W-1:0] cmd_ch;
    logic [7:0]      cmd_level;
    logic            cmd_immediate;

    modport master (
        output cmd_valid, cmd_ch, cmd_level, cmd_immediate,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_level, cmd_immediate,
        output cmd_ready
    );
endinterface

// File: rtl/led_fade_scheduler.sv
// Multi-channel LED PWM with a shared prescaler/phase counter and a round-robin fade scheduler
// that steps each channel's level one count per fade tick toward its commanded target.
module led_fade_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int PRESCALE = 2500,
    parameter int FADE_DIV = 100000
) (
    input  logic                 clk_50,
    input  logic                 reset,
    led_fade_scheduler_if.slave  cmd,
    output logic [NUM_CH-1:0]    led,
    output logic [NUM_CH-1:0]    busy,
    output logic                 o_dbg_state,
    output logic [3:0]           o_dbg_idx
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    logic [PW-1:0] r_presc;
    logic [7:0]    r_pwm_pos;
    logic [FW-1:0] r_fade;
    logic          w_presc_tc;
    logic          w_fade_tick;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_idx;
    logic [3:0]    w_idx_nxt;
    logic          w_ready;
    logic          w_accept;

    logic [7:0]    r_level  [NUM_CH];
    logic [7:0]    r_target [NUM_CH];

    assign w_presc_tc  = (r_presc == PW'(PRESCALE - 1));
    assign w_fade_tick = (r_fade == FW'(FADE_DIV - 1));

    // Free-running timebases; commands never touch them.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_presc   <= '0;
            r_pwm_pos <= '0;
            r_fade    <= '0;
        end else begin
            r_presc <= w_presc_tc ? '0 : r_presc + PW'(1);
            if (w_presc_tc) begin
                r_pwm_pos <= r_pwm_pos + 8'd1;
            end
            r_fade <= w_fade_tick ? '0 : r_fade + FW'(1);
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (w_fade_tick) begin
                    w_state_nxt = S_SWEEP;
                    w_idx_nxt   = '0;
                end
            end
            S_SWEEP: begin
                if (r_idx == 4'(NUM_CH - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign cmd.cmd_ready = w_ready & ~reset;
    assign w_accept      = cmd.cmd_valid & cmd.cmd_ready;

    // Commands are only accepted in IDLE, so a sweep update and a write never hit the same cycle.
    // Out-of-range channel numbers match no index and are silently dropped.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_level[i]  <= '0;
                r_target[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((r_state == S_SWEEP) && (r_idx == 4'(i))) begin
                    if (r_level[i] < r_target[i]) begin
                        r_level[i] <= r_level[i] + 8'd1;
                    end else if (r_level[i] > r_target[i]) begin
                        r_level[i] <= r_level[i] - 8'd1;
                    end
                end else if (w_accept && (cmd.cmd_ch == CH_W'(i))) begin
                    r_target[i] <= cmd.cmd_level;
                    if (cmd.cmd_immediate) begin
                        r_level[i] <= cmd.cmd_level;
                    end
                end
            end
        end
    end

    // Compare uses the phase before it advances, giving exactly L high steps per frame.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            led <= '0;
        end else if (w_presc_tc) begin
            for (int i = 0; i < NUM_CH; i++) begin
                led[i] <= (r_pwm_pos < r_level[i]);
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i] = (r_level[i] != r_target[i]);
        end
    end

    assign o_dbg_state = (r_state == S_SWEEP);
    assign o_dbg_idx   = r_idx;
endmodule

// File: tb/tb_led_fade_scheduler.sv
// Self-checking bench for led_fade_scheduler against a time-indexed behavioural model.
module tb_led_fade_scheduler;
    localparam int NUM_CH   = 4;
    localparam int CH_W     = 3;
    localparam int PRESCALE = 4;
    localparam int FADE_DIV = 16;
    localparam int OW       = 2 * NUM_CH + 1;

    logic              clk_50 = 1'b0;
    logic              reset  = 1'b1;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] busy;
    logic              dbg_state;
    logic [3:0]        dbg_idx;

    led_fade_scheduler_if #(.CH_W(CH_W)) cmd_if ();

    led_fade_scheduler #(
        .NUM_CH  (NUM_CH),
        .CH_W    (CH_W),
        .PRESCALE(PRESCALE),
        .FADE_DIV(FADE_DIV)
    ) dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .cmd        (cmd_if),
        .led        (led),
        .busy       (busy),
        .o_dbg_state(dbg_state),
        .o_dbg_idx  (dbg_idx)
    );

    always #5 clk_50 = ~clk_50;

    int compared   = 0;
    int mismatched = 0;
    int n_sent     = 0;
    int dut_accepts = 0;

    // Model: m_t is the number of clocks since reset released, which fixes every counter phase.
    int unsigned       m_t;
    int                m_level  [NUM_CH];
    int                m_target [NUM_CH];
    logic [NUM_CH-1:0] m_led;

    function automatic bit m_sweeping(int unsigned t);
        return (t >= FADE_DIV) && ((t % FADE_DIV) < NUM_CH);
    endfunction

    function automatic logic [OW-1:0] m_obs();
        logic [NUM_CH-1:0] b;
        for (int i = 0; i < NUM_CH; i++) b[i] = (m_level[i] != m_target[i]);
        return {m_led, b, (!reset && !m_sweeping(m_t))};
    endfunction

    always @(posedge clk_50) begin
        if (reset) begin
            m_t   <= 0;
            m_led <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_level[i]  <= 0;
                m_target[i] <= 0;
            end
        end else begin
            if ((m_t % PRESCALE) == PRESCALE - 1)
                for (int i = 0; i < NUM_CH; i++)
                    m_led[i] <= (int'((m_t / PRESCALE) % 256) < m_level[i]);
            if (m_sweeping(m_t)) begin
                if (m_level[m_t % FADE_DIV] < m_target[m_t % FADE_DIV])
                    m_level[m_t % FADE_DIV] <= m_level[m_t % FADE_DIV] + 1;
                else if (m_level[m_t % FADE_DIV] > m_target[m_t % FADE_DIV])
                    m_level[m_t % FADE_DIV] <= m_level[m_t % FADE_DIV] - 1;
            end else if (cmd_if.cmd_valid && int'(cmd_if.cmd_ch) < NUM_CH) begin
                m_target[cmd_if.cmd_ch] <= int'(cmd_if.cmd_level);
                if (cmd_if.cmd_immediate) m_level[cmd_if.cmd_ch] <= int'(cmd_if.cmd_level);
            end
            m_t <= m_t + 1;
        end
    end

    always @(posedge clk_50) begin
        if (cmd_if.cmd_valid && cmd_if.cmd_ready) dut_accepts <= dut_accepts + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", compared, mismatched);
        $fatal(1, "watchdog");
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_cmd(input int ch, input int lvl, input bit imm, output bit ok);
        int n;
        cmd_if.cmd_valid     = 1'b1;
        cmd_if.cmd_ch        = CH_W'(ch);
        cmd_if.cmd_level     = 8'(lvl);
        cmd_if.cmd_immediate = imm;
        n = 0;
        while (!cmd_if.cmd_ready && n < 64) begin
            @(negedge clk_50);
            n++;
        end
        if (n < 64) @(negedge clk_50);
        cmd_if.cmd_valid = 1'b0;
        ok = (n < 64);
        if (ok) n_sent++;
    endtask

    task automatic test_reset();
        logic [OW-1:0] obs;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk_50);
            compared++;
            if ({led, busy, cmd_if.cmd_ready} !== '0) begin
                mismatched++;
                $display("FAIL reset_hold: led=%b busy=%b ready=%b required all 0", led, busy, cmd_if.cmd_ready);
            end
        end
        reset = 1'b0;
        @(negedge clk_50);
        compared++;
        if (cmd_if.cmd_ready !== 1'b1 || dbg_state !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: ready=%b state=%b required ready=1 state=0", cmd_if.cmd_ready, dbg_state);
        end
        for (int c = 0; c < 2048; c++) begin
            @(negedge clk_50);
            obs = {led, busy, cmd_if.cmd_ready};
            compared++;
            if (obs !== m_obs() || led !== '0) begin
                mismatched++;
                $display("FAIL reset_idle_frames: t=%0d got %b required %b (led must stay 0)", m_t, obs, m_obs());
            end
        end
    endtask

    task automatic test_pwm_duty();
        bit ok;
        int high;
        logic others;
        send_cmd(1, 64, 1'b1, ok);
        compared++;
        if (!ok || busy !== '0) begin
            mismatched++;
            $display("FAIL pwm_write: accepted=%0b busy=%b required accepted=1 busy=0000", ok, busy);
        end
        high   = 0;
        others = 1'b0;
        for (int c = 0; c < 1024 + PRESCALE; c++) begin
            @(negedge clk_50);
            compared++;
            if ({led, busy, cmd_if.cmd_ready} !== m_obs()) begin
                mismatched++;
                $display("FAIL pwm_model: t=%0d got %b required %b", m_t, {led, busy, cmd_if.cmd_ready}, m_obs());
            end
            if (c >= PRESCALE) begin
                high   += int'(led[1]);
                others |= led[0] | led[2] | led[3];
            end
        end
        compared++;
        if (high != 64 * PRESCALE || others !== 1'b0) begin
            mismatched++;
            $display("FAIL pwm_duty: high=%0d others=%b required high=%0d others=0", high, others, 64 * PRESCALE);
        end
    endtask

    task automatic test_fade();
        bit ok;
        int n;
        int lvl_seq [2] = '{3, 0};
        for (int k = 0; k < 2; k++) begin
            send_cmd(2, lvl_seq[k], 1'b0, ok);
            compared++;
            if (!ok || busy[2] !== 1'b1) begin
                mismatched++;
                $display("FAIL fade_start%0d: accepted=%0b busy2=%b required 1/1", k, ok, busy[2]);
            end
            n = 0;
            while (n < 3 * FADE_DIV + NUM_CH + 4) begin
                @(negedge clk_50);
                n++;
                compared++;
                if ({led, busy, cmd_if.cmd_ready} !== m_obs()) begin
                    mismatched++;
                    $display("FAIL fade_model%0d: t=%0d got %b required %b", k, m_t, {led, busy, cmd_if.cmd_ready}, m_obs());
                end
                if (busy[2] === 1'b0) break;
            end
            compared++;
            if (n < 2 * FADE_DIV || n > 3 * FADE_DIV) begin
                mismatched++;
                $display("FAIL fade_duration%0d: busy cleared after %0d cycles required %0d..%0d", k, n, 2 * FADE_DIV, 3 * FADE_DIV);
            end
        end
    endtask

    task automatic test_hold_across_sweep();
        int n;
        int lows;
        int acc0;
        n = 0;
        while (!((m_t % FADE_DIV) == FADE_DIV - 1 && m_t > 0) && n < 64) begin
            @(negedge clk_50);
            n++;
        end
        @(negedge clk_50);
        cmd_if.cmd_valid     = 1'b1;
        cmd_if.cmd_ch        = CH_W'(3);
        cmd_if.cmd_level     = 8'd100;
        cmd_if.cmd_immediate = 1'b1;
        acc0 = dut_accepts;
        lows = 0;
        while (!cmd_if.cmd_ready && lows < 20) begin
            lows++;
            @(negedge clk_50);
        end
        compared++;
        if (lows != NUM_CH) begin
            mismatched++;
            $display("FAIL hold_ready_low: ready low %0d cycles required %0d", lows, NUM_CH);
        end
        @(negedge clk_50);
        cmd_if.cmd_valid = 1'b0;
        n_sent++;
        repeat (3) @(negedge clk_50);
        compared++;
        if (dut_accepts != acc0 + 1 || busy !== '0) begin
            mismatched++;
            $display("FAIL hold_accept: accepts=%0d busy=%b required accepts=%0d busy=0000", dut_accepts - acc0, busy, 1);
        end
        for (int c = 0; c < 2 * FADE_DIV; c++) begin
            @(negedge clk_50);
            compared++;
            if ({led, busy, cmd_if.cmd_ready} !== m_obs()) begin
                mismatched++;
                $display("FAIL hold_model: t=%0d got %b required %b", m_t, {led, busy, cmd_if.cmd_ready}, m_obs());
            end
        end
    endtask

    task automatic test_out_of_range();
        bit ok0, ok1;
        int acc0;
        logic [NUM_CH-1:0] busy0;
        acc0  = dut_accepts;
        busy0 = busy;
        send_cmd(5, 77, 1'b1, ok0);
        send_cmd(7, 200, 1'b0, ok1);
        compared++;
        if (!ok0 || !ok1 || dut_accepts != acc0 + 2 || busy !== busy0) begin
            mismatched++;
            $display("FAIL oor_handshake: ok=%0b%0b accepts=%0d busy=%b required ok=11 accepts=2 busy=%b", ok0, ok1, dut_accepts - acc0, busy, busy0);
        end
        for (int c = 0; c < 1024; c++) begin
            @(negedge clk_50);
            compared++;
            if ({led, busy, cmd_if.cmd_ready} !== m_obs()) begin
                mismatched++;
                $display("FAIL oor_model: t=%0d got %b required %b", m_t, {led, busy, cmd_if.cmd_ready}, m_obs());
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit ok0, ok1;
        int n;
        send_cmd(0, 10, 1'b1, ok0);
        send_cmd(0, 200, 1'b0, ok1);
        n = 0;
        while (dbg_state !== 1'b1 && n < 64) begin
            @(negedge clk_50);
            n++;
        end
        compared++;
        if (!ok0 || !ok1 || n >= 64) begin
            mismatched++;
            $display("FAIL rms_setup: ok=%0b%0b wait=%0d required ok=11 wait<64", ok0, ok1, n);
        end
        reset = 1'b1;
        @(negedge clk_50);
        compared++;
        if (led !== '0 || busy !== '0 || dbg_state !== 1'b0 || dbg_idx !== 4'd0 || cmd_if.cmd_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL rms_cleared: led=%b busy=%b state=%b idx=%0d ready=%b required all 0", led, busy, dbg_state, dbg_idx, cmd_if.cmd_ready);
        end
        reset = 1'b0;
        n = 0;
        while (n < 3 * FADE_DIV) begin
            @(negedge clk_50);
            n++;
            compared++;
            if ({led, busy, cmd_if.cmd_ready} !== m_obs() || led !== '0) begin
                mismatched++;
                $display("FAIL rms_model: t=%0d got %b required %b", m_t, {led, busy, cmd_if.cmd_ready}, m_obs());
            end
            if (dbg_state === 1'b1) break;
        end
        compared++;
        if (n != FADE_DIV) begin
            mismatched++;
            $display("FAIL rms_restart: first sweep after %0d cycles required %0d", n, FADE_DIV);
        end
    endtask

    task automatic test_random();
        bit ok;
        int gap;
        int sent0;
        int acc0;
        sent0 = n_sent;
        acc0  = dut_accepts;
        for (int k = 0; k < 150; k++) begin
            gap = $urandom_range(0, 20);
            for (int c = 0; c < gap; c++) begin
                @(negedge clk_50);
                compared++;
                if ({led, busy, cmd_if.cmd_ready} !== m_obs()) begin
                    mismatched++;
                    $display("FAIL random_model: t=%0d got %b required %b", m_t, {led, busy, cmd_if.cmd_ready}, m_obs());
                end
            end
            send_cmd($urandom_range(0, 7), $urandom_range(0, 255), 1'($urandom_range(0, 1)), ok);
            compared++;
            if (!ok) begin
                mismatched++;
                $display("FAIL random_accept: command %0d not accepted within 64 cycles", k);
            end
        end
        compared++;
        if (dut_accepts - acc0 != n_sent - sent0) begin
            mismatched++;
            $display("FAIL random_count: accepts=%0d required %0d", dut_accepts - acc0, n_sent - sent0);
        end
    endtask

    initial begin
        cmd_if.cmd_valid     = 1'b0;
        cmd_if.cmd_ch        = '0;
        cmd_if.cmd_level     = '0;
        cmd_if.cmd_immediate = 1'b0;
        test_reset();
        test_pwm_duty();
        test_fade();
        test_hold_across_sweep();
        test_out_of_range();
        test_reset_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
